// File: rtl/seq_det_ctrl.sv
// Run-time programmable serial pattern detector with match counting and threshold completion.
// Define SEQ_DET_OVERLAP_EN for overlapping detection; otherwise a match restarts the fill count.
module seq_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic [CNT_W-1:0]   cfg_thresh,
    output logic               cfg_err,
    input  logic               start,
    input  logic               stop,
    input  logic               x,
    input  logic               x_valid,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done
);
    localparam int FW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    logic [MAX_LEN-1:0] pat_q, hist_q;
    logic [3:0]         len_q;
    logic [CNT_W-1:0]   thresh_q, cnt_q;
    logic [FW-1:0]      fill_q;
    logic               cfg_ok_q, cfg_ready_q, cfg_err_q, match_q, busy_q, done_q;

    logic [MAX_LEN-1:0] hist_d, mask;
    logic [FW-1:0]      fill_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               hit, len_ok;

    // Candidate next values for a RUN sample; the FSM decides whether to commit them.
    always_comb begin
        hist_d = {hist_q[MAX_LEN-2:0], x};
        fill_d = (int'(fill_q) == MAX_LEN) ? fill_q : fill_q + 1'b1;
        cnt_d  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        mask   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
        hit    = (int'(fill_d) >= int'(len_q)) && (((hist_d ^ pat_q) & mask) == '0);
        len_ok = (cfg_len != 4'd0) && (int'(cfg_len) <= MAX_LEN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            thresh_q    <= '0;
            cfg_ok_q    <= 1'b0;
            hist_q      <= '0;
            fill_q      <= '0;
            cnt_q       <= '0;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
            match_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            match_q   <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    // A configuration offer takes priority over start in the same cycle.
                    if (cfg_valid && cfg_ready_q) begin
                        if (len_ok) begin
                            pat_q    <= cfg_pattern;
                            len_q    <= cfg_len;
                            thresh_q <= cfg_thresh;
                            cfg_ok_q <= 1'b1;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end else if (start && cfg_ok_q) begin
                        state_q     <= RUN;
                        hist_q      <= '0;
                        fill_q      <= '0;
                        cnt_q       <= '0;
                        done_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        cfg_ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        cfg_ready_q <= 1'b1;
                    end else if (x_valid) begin
                        hist_q <= hist_d;
                        fill_q <= fill_d;
                        if (hit) begin
                            match_q <= 1'b1;
                            cnt_q   <= cnt_d;
`ifdef SEQ_DET_OVERLAP_EN
`else
                            fill_q  <= '0;
`endif
                            if (thresh_q != '0 && cnt_d == thresh_q) begin
                                state_q     <= DONE;
                                done_q      <= 1'b1;
                                busy_q      <= 1'b0;
                                cfg_ready_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    cfg_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;
    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl; expectations follow the SEQ_DET_OVERLAP_EN setting.
module tb_seq_det_ctrl;
    logic       clk = 1'b0;
    logic       rst, cfg_valid, cfg_ready, cfg_err, start, stop, x, x_valid, match, busy, done;
    logic [7:0] cfg_pattern, cfg_thresh, match_cnt;
    logic [3:0] cfg_len;
    int checks = 0;
    int errors = 0;

    seq_det_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_thresh(cfg_thresh),
        .cfg_err(cfg_err), .start(start), .stop(stop), .x(x), .x_valid(x_valid),
        .match(match), .match_cnt(match_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t);
        cfg_valid = 1'b1; cfg_pattern = p; cfg_len = l; cfg_thresh = t;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic bit_in(input logic b);
        x_valid = 1'b1; x = b;
        step();
        x_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(cfg_ready), 1);
        chk({tag, "_busy"},  32'(busy),      0);
        chk({tag, "_done"},  32'(done),      0);
        chk({tag, "_cnt"},   32'(match_cnt), 0);
        chk({tag, "_match"}, 32'(match),     0);
        chk({tag, "_err"},   32'(cfg_err),   0);
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_thresh = '0;
        start = 1'b0; stop = 1'b0; x = 1'b0; x_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        chk_reset("rst");

        // Illegal lengths are rejected and leave no usable configuration
        cfg(8'h05, 4'd0, 8'd0);
        chk("err_len0", 32'(cfg_err), 1);
        step();
        chk("err_clear", 32'(cfg_err), 0);
        cfg(8'h05, 4'd9, 8'd0);
        chk("err_len9", 32'(cfg_err), 1);
        go();
        chk("start_nocfg_busy", 32'(busy), 0);

        // Config and start together: config accepted, start dropped
        start = 1'b1;
        cfg(8'h05, 4'd3, 8'd0);
        start = 1'b0;
        chk("cfg_ok_err", 32'(cfg_err), 0);
        chk("cfg_start_same_busy", 32'(busy), 0);
        go();
        chk("run_busy", 32'(busy), 1);
        chk("run_ready", 32'(cfg_ready), 0);

        // 101 on 10101
        bit_in(1'b1); chk("s1_b1", 32'(match), 0);
        bit_in(1'b0); chk("s1_b2", 32'(match), 0);
        bit_in(1'b1); chk("s1_b3", 32'(match), 1);
        chk("s1_cnt3", 32'(match_cnt), 1);
        bit_in(1'b0); chk("s1_b4", 32'(match), 0);
        bit_in(1'b1);
`ifdef SEQ_DET_OVERLAP_EN
        chk("s1_b5", 32'(match), 1);
        chk("s1_cnt5", 32'(match_cnt), 2);
`else
        chk("s1_b5", 32'(match), 0);
        chk("s1_cnt5", 32'(match_cnt), 1);
`endif
        stop = 1'b1; step(); stop = 1'b0;
        chk("s1_stop_busy", 32'(busy), 0);
        chk("s1_stop_ready", 32'(cfg_ready), 1);
`ifdef SEQ_DET_OVERLAP_EN
        chk("s1_hold_cnt", 32'(match_cnt), 2);
`else
        chk("s1_hold_cnt", 32'(match_cnt), 1);
`endif

        // 1101 with threshold 2
        cfg(8'h0D, 4'd4, 8'd2);
        go();
        chk("s2_cnt_clr", 32'(match_cnt), 0);
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        chk("s2_m1", 32'(match), 1);
        chk("s2_cnt1", 32'(match_cnt), 1);
        chk("s2_busy1", 32'(busy), 1);
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
        chk("s2_b7", 32'(match), 0);
        bit_in(1'b1);
        chk("s2_m2", 32'(match), 1);
        chk("s2_done", 32'(done), 1);
        chk("s2_busy2", 32'(busy), 0);
        chk("s2_cnt2", 32'(match_cnt), 2);
        chk("s2_ready", 32'(cfg_ready), 1);
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        chk("s2_after_match", 32'(match), 0);
        chk("s2_after_cnt", 32'(match_cnt), 2);
        chk("s2_after_done", 32'(done), 1);

        // Stop discards the coinciding sample and a restart clears history
        cfg(8'h05, 4'd3, 8'd0);
        go();
        chk("s3_done_clr", 32'(done), 0);
        chk("s3_busy", 32'(busy), 1);
        bit_in(1'b1); bit_in(1'b0);
        stop = 1'b1; x_valid = 1'b1; x = 1'b1;
        step();
        stop = 1'b0; x_valid = 1'b0;
        chk("s3_stop_busy", 32'(busy), 0);
        chk("s3_stop_match", 32'(match), 0);
        chk("s3_stop_cnt", 32'(match_cnt), 0);
        go();
        bit_in(1'b1); chk("s3_r1", 32'(match), 0);
        bit_in(1'b0); chk("s3_r2", 32'(match), 0);
        bit_in(1'b1); chk("s3_r3", 32'(match), 1);
        chk("s3_cnt", 32'(match_cnt), 1);

        // Reset mid-run drops the configuration
        rst = 1'b1; step(); rst = 1'b0;
        chk_reset("mid_rst");
        go();
        chk("mid_rst_start_busy", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
